// File: rtl/square_fixed_pkg.sv
// Shared fixed-point constants and state encoding for the ray-tracer
// squarer and square-root units.
package square_fixed_pkg;

   localparam int FIXED_POINT_BITS    = 4;
   localparam int SR_FIXED_POINT_BITS = 16;

   typedef enum logic [1:0] {
      SQ_IDLE,
      SQ_MUL,
      SQ_ROUND,
      SQ_DONE
   } sq_state_t;

endpackage

// File: rtl/square_fixed.sv
// Iterative shift-add squarer: unsigned Q8.16 X in, rounded and saturated
// Q8.4 X^2 out. One product bit per clock, start/busy/done handshake.
module square_fixed
   import square_fixed_pkg::*;
#(
   parameter int IN_W     = 24,
   parameter int IN_FRAC  = SR_FIXED_POINT_BITS,
   parameter int OUT_W    = 12,
   parameter int OUT_FRAC = FIXED_POINT_BITS
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             start,
   input  logic [IN_W-1:0]  X,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] Y,
   output logic             ovf
);

   localparam int P_W   = 2 * IN_W;
   localparam int SH    = 2 * IN_FRAC - OUT_FRAC;
   localparam int CNT_W = $clog2(IN_W);

   localparam logic [P_W:0]       HALF  = (P_W + 1)'(1) << (SH - 1);
   localparam logic [P_W:0]       Y_MAX = {{(P_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(IN_W - 1);

   sq_state_t        state;
   logic [P_W-1:0]   acc;
   logic [P_W-1:0]   mcand;
   logic [IN_W-1:0]  mult;
   logic [CNT_W-1:0] cnt;

   // Extra top bit keeps the half-LSB add from wrapping when acc is all ones.
   function automatic logic [P_W:0] round_half_up(input logic [P_W-1:0] p);
      return ({1'b0, p} + HALF) >> SH;
   endfunction

   function automatic logic [OUT_W:0] saturate(input logic [P_W:0] r);
      if (r > Y_MAX)
         return {1'b1, {OUT_W{1'b1}}};
      return {1'b0, r[OUT_W-1:0]};
   endfunction

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= SQ_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         Y     <= '0;
         ovf   <= 1'b0;
         acc   <= '0;
         mcand <= '0;
         mult  <= '0;
         cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            SQ_IDLE: begin
               if (start) begin
                  mcand <= {{IN_W{1'b0}}, X};
                  mult  <= X;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SQ_MUL;
               end
            end
            // mcand is pre-shifted each step, so it always equals X << cnt.
            SQ_MUL: begin
               if (mult[0])
                  acc <= acc + mcand;
               mcand <= mcand << 1;
               mult  <= mult >> 1;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST)
                  state <= SQ_ROUND;
            end
            SQ_ROUND: begin
               {ovf, Y} <= saturate(round_half_up(acc));
               done     <= 1'b1;
               state    <= SQ_DONE;
            end
            SQ_DONE: begin
               busy  <= 1'b0;
               state <= SQ_IDLE;
            end
            default: state <= SQ_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_square_fixed.sv
// Scoreboard bench for square_fixed: stimulus pushes expected results,
// a negedge monitor pops and compares each done pulse.
module tb_square_fixed;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic        start = 1'b0;
   logic [23:0] X = '0;
   logic        busy;
   logic        done;
   logic [11:0] Y;
   logic        ovf;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic prev_done = 1'b0;

   typedef struct {
      logic [23:0] x;
      logic [11:0] y;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t q[$];

   square_fixed dut (
      .clk   (clk),
      .rst_  (rst_),
      .start (start),
      .X     (X),
      .busy  (busy),
      .done  (done),
      .Y     (Y),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: exact square in Q16.32, round half up to Q.4, clamp to 12 bits.
   function automatic logic [12:0] model(input logic [23:0] x);
      longint unsigned p;
      longint unsigned r;
      p = 64'(x) * 64'(x);
      r = (p + (64'd1 << 27)) >> 28;
      if (r > 64'd4095)
         return {1'b1, 12'hFFF};
      return {1'b0, r[11:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [23:0] x);
      exp_t e;
      logic [12:0] m;
      m     = model(x);
      e.x   = x;
      e.y   = m[11:0];
      e.ovf = m[12];
      e.acc = cyc + 1;
      q.push_back(e);
   endtask

   // Called at a negedge; returns at a negedge where the DUT is idle.
   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (!busy) return;
         @(negedge clk);
      end
      chk("wait_idle_timeout", 32'(busy), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_) begin
         if (done) begin
            if (prev_done)
               chk("done_two_cycles", 32'd1, 32'd0);
            if (q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk($sformatf("Y[x=%06h]", e.x), 32'(Y), 32'(e.y));
               chk($sformatf("ovf[x=%06h]", e.x), 32'(ovf), 32'(e.ovf));
               chk($sformatf("latency[x=%06h]", e.x), 32'(cyc - e.acc), 32'd25);
            end
         end else if (q.size() > 0 && cyc >= q[0].acc) begin
            chk("busy_in_flight", 32'(busy), 32'd1);
         end
         prev_done <= done;
      end else begin
         prev_done <= 1'b0;
      end
   end

   task automatic issue(input logic [23:0] x, input bit repulse);
      @(negedge clk);
      wait_idle();
      X     = x;
      start = 1'b1;
      push(x);
      @(negedge clk);
      start = 1'b0;
      X     = 24'($urandom);
      if (repulse) begin
         repeat (5) @(negedge clk);
         start = 1'b1;
         X     = 24'h030000;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic burst(input int n);
      int last_acc;
      @(negedge clk);
      wait_idle();
      start = 1'b1;
      X     = 24'($urandom) & 24'h1FFFFF;
      push(X);
      last_acc = cyc + 1;
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         wait_idle();
         chk("burst_period", 32'(cyc + 1 - last_acc), 32'd27);
         X = (i % 2 == 0) ? 24'($urandom) : (24'($urandom) & 24'h0FFFFF);
         push(X);
         last_acc = cyc + 1;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
      chk("drain_queue_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic [23:0] dir [9];
      dir = '{24'h020000, 24'h018000, 24'h0FF800, 24'h100000, 24'hFFFFFF,
              24'h004000, 24'h000100, 24'h0FFFFF, 24'h000000};

      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_Y", 32'(Y), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_ = 1'b1;

      foreach (dir[i]) issue(dir[i], i == 1);
      drain();

      for (int i = 0; i < 20; i++) begin
         case (i % 3)
            0:       issue(24'($urandom), 1'b0);
            1:       issue(24'($urandom) & 24'h0FFFFF, 1'b0);
            default: issue(24'($urandom) & 24'h00FFFF, i == 5);
         endcase
      end
      drain();

      burst(5);
      drain();

      // Asynchronous reset in the middle of a multiply.
      @(negedge clk);
      wait_idle();
      X     = 24'h020000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2;
      rst_ = 1'b0;
      q.delete();
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      chk("async_rst_Y", 32'(Y), 32'd0);
      chk("async_rst_ovf", 32'(ovf), 32'd0);
      repeat (3) @(negedge clk);
      rst_ = 1'b1;
      repeat (30) @(negedge clk);
      chk("no_done_after_rst", 32'(q.size()), 32'd0);

      issue(24'h018000, 1'b0);
      issue(24'h0FFFFF, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, %0d failures so far", fails);
      $fatal(1);
   end

endmodule

// File: doc/square_fixed.md
Name: square_fixed

Overview:
- Iterative shift-add squarer; the inverse of the square-root unit.
- Takes an unsigned Q8.16 value X and returns Y = X² in the Q8.4 format the square-root unit accepts as its input A.
- Used in the ray-tracer datapath to square distances and lengths, and to re-square square-root results for self-check.
- Uses a start/busy/done handshake, one operand in flight, one product bit per clock.

Parameters:
- IN_W, 24, input width (unsigned, IN_FRAC fraction bits)
- IN_FRAC, 16, input fraction bits (equals SR_FIXED_POINT_BITS)
- OUT_W, 12, output width (unsigned, OUT_FRAC fraction bits)
- OUT_FRAC, 4, output fraction bits (equals FIXED_POINT_BITS)

Ports:
- clk  in  1  system clock, rising edge
- rst_  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- X  in  IN_W  operand, captured on the edge that accepts start
- busy  out  1  high from acceptance until DONE is left
- done  out  1  one-cycle pulse; Y and ovf valid
- Y  out  OUT_W  rounded, saturated X², Q8.4
- ovf  out  1  saturation occurred; valid with done

Behaviour:
- Interface (already decided): one clock, clk; reset rst_ is asynchronous and active-low.
- Reset (any state, including mid-operation):
  - state=IDLE; busy=0, done=0, Y=0, ovf=0
  - internal accumulator, operand and counter cleared
  - any in-flight result is discarded; no done follows.
- States: IDLE, MUL, ROUND, DONE.
- IDLE:
  - if start=1 at the edge: latch X into multiplicand and multiplier registers, accumulator P (2*IN_W = 48 bits) = 0, cnt = 0, busy=1, state→MUL
  - else stay in IDLE.
- MUL, one edge per multiplier bit, LSB first:
  - if mult[0] then P += mcand << cnt; mult >>= 1; cnt++
  - after cnt = IN_W-1 is processed (IN_W edges in MUL), state→ROUND.
- ROUND, single edge:
  - R = (P + 2^(SH-1)) >> SH, where SH = 2*IN_FRAC - OUT_FRAC = 28 (round half up)
  - if R > 2^OUT_W - 1: Y = 0xFFF, ovf=1; else Y = R[OUT_W-1:0], ovf=0
  - done=1, state→DONE.
- DONE, single edge: done=0, busy=0, state→IDLE.
- Latency: done is high during the cycle after the (IN_W+1)th edge following acceptance, i.e. 25 edges after acceptance for defaults.
- Y and ovf hold their value after done until the next ROUND or reset.
- Throughput: one result per IN_W+3 cycles; start held high continuously re-accepts on the first edge back in IDLE.
- start while busy=1 (MUL, ROUND, DONE) is ignored; X changing while busy has no effect.
- Widths:
  - accumulator is exactly 2*IN_W bits; no intermediate overflow is possible
  - the rounding add is done at 2*IN_W+1 bits so that P = max cannot wrap.
- X=0 yields Y=0, ovf=0, with the same latency; there is no early termination.

Decomposition:
- Shared types package:
  - FIXED_POINT_BITS (4) and SR_FIXED_POINT_BITS (16), already present; the defaults for OUT_FRAC and IN_FRAC are derived from them
  - typedef enum for the squarer state (sq_state_t).
- No sub-module: the shift-add datapath and the FSM stay in one module, about 150 lines.

Test Plan:
- Reset, then X=0x020000 (2.0), start pulse → done exactly 25 edges after acceptance; Y=0x040 (4.0), ovf=0; busy high throughout.
- X=0x018000 (1.5) → Y=0x024 (2.25). X=0x0FF800 (15.96875) → Y=0xFF0 (exact 4080.0156, rounds down), ovf=0.
- Saturation:
  - X=0x100000 (16.0) → Y=0xFFF, ovf=1
  - X=0xFFFFFF → Y=0xFFF, ovf=1, no accumulator wrap.
- Rounding:
  - X=0x004000 (0.25) → Y=0x001
  - X=0x000100 → Y=0x000
  - X=0x0FFFFF → Y=0xFFF, ovf=1 (rounding pushes the result past the limit).
- Handshake:
  - start re-pulsed with X=0x030000 mid-MUL → ignored; the first result is unchanged
  - start held high → back-to-back results every 27 cycles; done never high two consecutive cycles.
- rst_ asserted asynchronously at MUL cycle 10 → outputs are 0 immediately with no clock edge; no done; a fresh start afterwards produces a correct result.
